// File: rtl/one_hot_mux_pipe.sv
// One-hot selected N:1 mux with valid/ready flow control, an elastic
// output pipeline and one-hot violation reporting.
module one_hot_mux_pipe #(
   parameter int WIDTH         = 32,
   parameter int CNT           = 5,
   parameter int STAGES        = 1,
   parameter int ONE_HOT_CHECK = 1,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH*CNT-1:0] din,
   input  logic [CNT-1:0]       din_vld,
   output logic [CNT-1:0]       din_rdy,
   input  logic [CNT-1:0]       sel,
   output logic [WIDTH-1:0]     dout,
   output logic                 dout_vld,
   input  logic                 dout_rdy,
   output logic                 err,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_cnt,
   input  logic                 err_clr
);

   logic             none;
   logic             multi;
   logic             all_vld;
   logic             go;
   logic             accept;
   logic             xfer;
   logic             viol;
   logic [WIDTH-1:0] mux;

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] load;
   logic [STAGES-1:0] in_vld;
   logic [WIDTH-1:0]  dat    [STAGES];
   logic [WIDTH-1:0]  in_dat [STAGES];

   assign none    = (sel == '0);
   assign multi   = |(sel & (sel - CNT'(1)));
   assign all_vld = &(din_vld | ~sel);

   // legacy mode lets a multi-hot select through once every selected
   // channel is valid; checked mode blocks it outright
   assign go      = ~multi | ((ONE_HOT_CHECK == 0) & all_vld);
   assign accept  = load[0];
   assign din_rdy = sel & {CNT{accept & go & ~rst}};
   assign xfer    = accept & go & all_vld & ~none & ~rst;
   assign viol    = multi & (ONE_HOT_CHECK != 0);

   always_comb begin
      mux = '0;
      for (int c = 0; c < CNT; c++)
         mux = mux | (din[c*WIDTH +: WIDTH] & {WIDTH{sel[c]}});
   end

   // a stage may load when any stage from it to the output has room,
   // or the output is being drained this cycle
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      assign load[g] = dout_rdy | ~(&vld[STAGES-1:g]);
      if (g == 0) begin : g_head
         assign in_vld[g] = xfer;
         assign in_dat[g] = mux;
      end else begin : g_body
         assign in_vld[g] = vld[g-1];
         assign in_dat[g] = dat[g-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < STAGES; i++)
            dat[i] <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (load[i]) begin
               vld[i] <= in_vld[i];
               if (in_vld[i])
                  dat[i] <= in_dat[i];
            end
         end
      end
   end

   assign dout     = dat[STAGES-1];
   assign dout_vld = vld[STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         err        <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
      end else begin
         err <= viol;
         if (err_clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
         end else if (viol) begin
            err_sticky <= 1'b1;
            if (~&err_cnt)
               err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end
   end

endmodule
